// File: rtl/regfile_wr_demux.sv
// Write side of a 16-entry register bank: a small in-order request FIFO feeding a
// 1:16 write demux, with every register value driven out in parallel.
// Optional build macro R0_ZERO_EN: register 0 reads as constant zero. Writes to it
// still occupy a FIFO slot and a commit cycle.
module regfile_wr_demux #(
  parameter int unsigned DATA_W     = 64,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [2:0]        pend_cnt,
  output logic              idle,
  output logic [DATA_W-1:0] dout_0,
  output logic [DATA_W-1:0] dout_1,
  output logic [DATA_W-1:0] dout_2,
  output logic [DATA_W-1:0] dout_3,
  output logic [DATA_W-1:0] dout_4,
  output logic [DATA_W-1:0] dout_5,
  output logic [DATA_W-1:0] dout_6,
  output logic [DATA_W-1:0] dout_7,
  output logic [DATA_W-1:0] dout_8,
  output logic [DATA_W-1:0] dout_9,
  output logic [DATA_W-1:0] dout_10,
  output logic [DATA_W-1:0] dout_11,
  output logic [DATA_W-1:0] dout_12,
  output logic [DATA_W-1:0] dout_13,
  output logic [DATA_W-1:0] dout_14,
  output logic [DATA_W-1:0] dout_15
);

  localparam int unsigned NumRegs  = 16;
  localparam int unsigned PtrW     = $clog2(FIFO_DEPTH);
  localparam logic [2:0]  DepthCnt = 3'(FIFO_DEPTH);

  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [2:0]        r_cnt;
  logic [DATA_W-1:0] r_regs [NumRegs];

  logic              w_push;
  logic              w_pop;
  logic [2:0]        w_cnt_d;
  logic [ADDR_W-1:0] w_head_addr;
  logic [DATA_W-1:0] w_head_data;
  logic [NumRegs-1:0] w_en;

  // Full/empty come from the occupancy count; pop-same-cycle never frees a slot early.
  assign wr_ready    = rst_n && (r_cnt < DepthCnt);
  assign w_push      = wr_valid && wr_ready;
  assign w_pop       = (r_cnt != 3'd0);
  assign w_head_addr = r_fifo_addr[r_rd_ptr];
  assign w_head_data = r_fifo_data[r_rd_ptr];

  // Occupancy next-state from push/pop.
  always_comb begin
    w_cnt_d = r_cnt;
    unique case ({w_push, w_pop})
      2'b10:   w_cnt_d = r_cnt + 3'd1;
      2'b01:   w_cnt_d = r_cnt - 3'd1;
      default: w_cnt_d = r_cnt;
    endcase
  end

  // FIFO storage, pointers and occupancy; pointers wrap naturally (depth is a power of 2).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
        r_fifo_addr[i] <= '0;
        r_fifo_data[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_push) begin
        r_fifo_addr[r_wr_ptr] <= wr_addr;
        r_fifo_data[r_wr_ptr] <= wr_data;
        r_wr_ptr              <= r_wr_ptr + PtrW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PtrW'(1);
      end
      r_cnt <= w_cnt_d;
    end
  end

  // 1:16 demux of the head entry; gated by non-empty so stale entries never write.
  always_comb begin
    w_en = '0;
    for (int i = 0; i < int'(NumRegs); i++) begin
      w_en[i] = w_pop && (w_head_addr == ADDR_W'(i));
    end
  end

  // Register bank commit, at most one register per edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NumRegs); i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(NumRegs); i++) begin
`ifdef R0_ZERO_EN
        if (w_en[i] && (i != 0)) begin
          r_regs[i] <= w_head_data;
        end
`else
        if (w_en[i]) begin
          r_regs[i] <= w_head_data;
        end
`endif
      end
    end
  end

  assign pend_cnt = r_cnt;
  assign idle     = (r_cnt == 3'd0);

  assign dout_0  = r_regs[0];
  assign dout_1  = r_regs[1];
  assign dout_2  = r_regs[2];
  assign dout_3  = r_regs[3];
  assign dout_4  = r_regs[4];
  assign dout_5  = r_regs[5];
  assign dout_6  = r_regs[6];
  assign dout_7  = r_regs[7];
  assign dout_8  = r_regs[8];
  assign dout_9  = r_regs[9];
  assign dout_10 = r_regs[10];
  assign dout_11 = r_regs[11];
  assign dout_12 = r_regs[12];
  assign dout_13 = r_regs[13];
  assign dout_14 = r_regs[14];
  assign dout_15 = r_regs[15];

endmodule

// File: tb/tb_regfile_wr_demux.sv
// Self-checking bench for regfile_wr_demux: directed scenarios followed by random
// traffic, compared against a queue-and-array reference model.
module tb_regfile_wr_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [3:0]  wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [2:0]  pend_cnt;
  logic        idle;
  logic [63:0] dout [16];

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pending writes in arrival order plus the architectural registers.
  logic [67:0] m_q [$];
  logic [63:0] m_regs [16];

  always #5 clk = ~clk;

  regfile_wr_demux dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (wr_valid),
    .wr_ready (wr_ready),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .pend_cnt (pend_cnt),
    .idle     (idle),
    .dout_0   (dout[0]),
    .dout_1   (dout[1]),
    .dout_2   (dout[2]),
    .dout_3   (dout[3]),
    .dout_4   (dout[4]),
    .dout_5   (dout[5]),
    .dout_6   (dout[6]),
    .dout_7   (dout[7]),
    .dout_8   (dout[8]),
    .dout_9   (dout[9]),
    .dout_10  (dout[10]),
    .dout_11  (dout[11]),
    .dout_12  (dout[12]),
    .dout_13  (dout[13]),
    .dout_14  (dout[14]),
    .dout_15  (dout[15])
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    m_q.delete();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
  endtask

  // One clock edge of the reference: commit the oldest pending write, then accept.
  task automatic model_edge(input bit v, input logic [3:0] a, input logic [63:0] d);
    logic [67:0] e;
    bit          acc;
    if (rst_n) begin
      acc = v && (m_q.size() < 4);
      if (m_q.size() > 0) begin
        e = m_q.pop_front();
`ifdef R0_ZERO_EN
        if (e[67:64] != 4'd0) m_regs[e[67:64]] = e[63:0];
`else
        m_regs[e[67:64]] = e[63:0];
`endif
      end
      if (acc) m_q.push_back({a, d});
    end
  endtask

  task automatic check_state(input string ctx);
    chk({ctx, ":pend_cnt"}, 64'(pend_cnt), 64'(m_q.size()));
    chk({ctx, ":idle"}, 64'(idle), 64'(m_q.size() == 0));
    for (int i = 0; i < 16; i++) chk($sformatf("%s:dout_%0d", ctx, i), dout[i], m_regs[i]);
  endtask

  // Drive at the falling edge, check ready, clock once, check registered outputs.
  task automatic step(input string ctx, input bit v, input logic [3:0] a, input logic [63:0] d);
    wr_valid = v;
    wr_addr  = a;
    wr_data  = d;
    #1;
    chk({ctx, ":wr_ready"}, 64'(wr_ready), 64'(rst_n && (m_q.size() < 4)));
    @(posedge clk);
    model_edge(v, a, d);
    @(negedge clk);
    check_state(ctx);
  endtask

  initial begin
    model_clear();

    // Held in reset: outputs cleared and no acceptance.
    repeat (3) @(negedge clk);
    chk("rst:wr_ready", 64'(wr_ready), 64'd0);
    check_state("rst");

    // Test 1: release reset.
    rst_n = 1'b1;
    #1;
    chk("rel:wr_ready", 64'(wr_ready), 64'd1);
    check_state("rel");

    // Invalid request with unknown address/data must be ignored.
    step("xin", 1'b0, 4'bxxxx, 64'hx);
    step("xin2", 1'b0, 4'bxxxx, 64'hx);

    // Test 2: single write, visible after the commit edge.
    step("t2_acc", 1'b1, 4'd5, 64'hDEAD_BEEF_0000_0005);
    chk("t2_not_yet", dout[5], 64'd0);
    step("t2_commit", 1'b0, 4'd0, 64'd0);
    chk("t2_dout5", dout[5], 64'hDEAD_BEEF_0000_0005);

    // Test 3: same address twice; earlier value visible for one cycle.
    step("t3_a", 1'b1, 4'd3, 64'd1);
    step("t3_b", 1'b1, 4'd3, 64'd2);
    chk("t3_first", dout[3], 64'd1);
    step("t3_c", 1'b0, 4'd0, 64'd0);
    chk("t3_second", dout[3], 64'd2);

    // Test 4: 16 back-to-back writes; occupancy never exceeds one.
    for (int i = 0; i < 16; i++) begin
      step($sformatf("t4_%0d", i), 1'b1, 4'(i), 64'(i * 'h11));
      chk("t4_pend_le1", 64'(pend_cnt <= 3'd1), 64'd1);
    end
    step("t4_drain", 1'b0, 4'd0, 64'd0);
    chk("t4_idle", 64'(idle), 64'd1);
    for (int i = 1; i < 16; i++) chk($sformatf("t4_val_%0d", i), dout[i], 64'(i * 'h11));

    // Test 5: asynchronous reset mid-operation.
    step("t5_a", 1'b1, 4'd7, 64'h7777);
    step("t5_b", 1'b1, 4'd8, 64'h8888);
    step("t5_c", 1'b1, 4'd9, 64'h9999);
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_clear();
    chk("t5_wr_ready", 64'(wr_ready), 64'd0);
    check_state("t5_rst");
    @(negedge clk);
    check_state("t5_hold");
    rst_n = 1'b1;

    // Test 6: write to register 0.
    step("t6_acc", 1'b1, 4'd0, 64'hFFFF);
    step("t6_commit", 1'b0, 4'd0, 64'd0);
`ifdef R0_ZERO_EN
    chk("t6_dout0", dout[0], 64'd0);
`else
    chk("t6_dout0", dout[0], 64'hFFFF);
`endif

    // Random traffic.
    for (int n = 0; n < 300; n++) begin
      step("rnd", 1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
           {32'($urandom), 32'($urandom)});
    end
    step("rnd_drain", 1'b0, 4'd0, 64'd0);
    chk("rnd_idle", 64'(idle), 64'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
